// File: rtl/sevenseg_pkg.sv
// Shared constants for the 8-digit seven-segment scan driver.
// Glyphs are active-low in {CG..CA} order, indexed by nibble value.
// No logic here; pure parameters.
package sevenseg_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int DIG_BITS   = $clog2(NUM_DIGITS);

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   // Entry k is the glyph for nibble k (entry 0 sits in the low bits).
   localparam logic [15:0][6:0] GLYPHS = {
      7'h0E,  // F
      7'h06,  // E
      7'h21,  // d
      7'h46,  // C
      7'h03,  // b
      7'h08,  // A
      7'h10,  // 9
      7'h00,  // 8
      7'h78,  // 7
      7'h02,  // 6
      7'h12,  // 5
      7'h19,  // 4
      7'h30,  // 3
      7'h24,  // 2
      7'h79,  // 1
      7'h40   // 0
   };

endpackage

// File: rtl/hex7seg.sv
// Nibble to active-low seven-segment glyph decode.
// Latency: combinational, zero cycles.
// Backpressure: none.
module hex7seg
   import sevenseg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = GLYPHS[nib];

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed 8-digit common-anode display driver with frame-aligned double buffering.
// Latency: outputs registered, one cycle behind the div/digit scan state.
// Backpressure: none; load is accepted every cycle. Optional SEVENSEG_LZS_EN blanks leading zeros.
module sevenseg_scan
   import sevenseg_pkg::*;
#(
   parameter int DIV_BITS = 17,
   parameter int GUARD    = 4
)(
   input  logic        CLK100MHZ,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  blank_in,
   output logic [6:0]  seg,
   output logic [7:0]  an,
   output logic        dp,
   output logic        pending,
   output logic        frame_done
);

   logic [DIV_BITS-1:0] div;
   logic [DIG_BITS-1:0] digit;

   logic [31:0] pend_val, act_val;
   logic [7:0]  pend_dp, act_dp;
   logic [7:0]  pend_blank, act_blank;

   logic        slot_end, boundary;
   logic [7:0]  lz_mask;
   logic        dark;
   logic [6:0]  glyph;

   assign slot_end = &div;
   assign boundary = slot_end && (digit == DIG_BITS'(NUM_DIGITS - 1));

   // Prescaler and digit counter: advance one digit per slot.
   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         div   <= '0;
         digit <= '0;
      end else begin
         div <= div + 1'b1;
         if (slot_end)
            digit <= digit + 1'b1;
      end
   end

   // Double buffer: loads park in pending, promoted only at the frame boundary.
   // A load landing on the boundary bypasses pending and drops any older word.
   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         act_val    <= '0;
         act_dp     <= '0;
         act_blank  <= '0;
         pending    <= 1'b0;
      end else if (boundary) begin
         if (load) begin
            act_val   <= data_in;
            act_dp    <= dp_in;
            act_blank <= blank_in;
         end else if (pending) begin
            act_val   <= pend_val;
            act_dp    <= pend_dp;
            act_blank <= pend_blank;
         end
         pending <= 1'b0;
      end else if (load) begin
         pend_val   <= data_in;
         pend_dp    <= dp_in;
         pend_blank <= blank_in;
         pending    <= 1'b1;
      end
   end

`ifdef SEVENSEG_LZS_EN
   logic [DIG_BITS-1:0] msd;

   // Leading-zero mask: digits above the highest nonzero nibble go dark; digit 0 never does.
   always_comb begin
      msd     = '0;
      lz_mask = '0;
      for (int k = 1; k < NUM_DIGITS; k++)
         if (act_val[4*k +: 4] != 4'h0)
            msd = DIG_BITS'(k);
      for (int k = 0; k < NUM_DIGITS; k++)
         lz_mask[k] = (DIG_BITS'(k) > msd);
   end
`else
   assign lz_mask = '0;
`endif

   hex7seg u_hex7seg (
      .nib (act_val[4*digit +: 4]),
      .seg (glyph)
   );

   assign dark = (div < DIV_BITS'(GUARD)) || act_blank[digit] || lz_mask[digit];

   // Output registers: guard window and blanked digits keep every pin inactive.
   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         an         <= AN_OFF;
         seg        <= SEG_OFF;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;
         if (dark) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
         end else begin
            an  <= ~(8'b1 << digit);
            seg <= glyph;
            dp  <= ~act_dp[digit];
         end
      end
   end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Randomized bench for sevenseg_scan against a cycle-count reference model.
// Model derives slot position and digit from elapsed cycles since reset release.
// Checks outputs every cycle; directed loads cover boundary, overwrite and blanking cases.
module tb_sevenseg_scan;

   localparam int DB    = 4;
   localparam int GD    = 2;
   localparam int SLOT  = 1 << DB;
   localparam int FRAME = 8 * SLOT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [31:0] data_in = '0;
   logic [7:0]  dp_in = '0;
   logic [7:0]  blank_in = '0;
   logic [6:0]  seg;
   logic [7:0]  an;
   logic        dp;
   logic        pending;
   logic        frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   int          m_t;
   logic [31:0] m_act_val, m_pend_val;
   logic [7:0]  m_act_dp, m_pend_dp, m_act_blank, m_pend_blank;
   logic        m_pending;
   logic [7:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dp, exp_fd;

   sevenseg_scan #(.DIV_BITS(DB), .GUARD(GD)) dut (
      .CLK100MHZ  (clk),
      .rst_n      (rst_n),
      .load       (load),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .seg        (seg),
      .an         (an),
      .dp         (dp),
      .pending    (pending),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, expv);
      end
   endtask

   function automatic logic [6:0] ref_glyph(input int v);
      case (v)
         0: return 7'b1000000;   1: return 7'b1111001;
         2: return 7'b0100100;   3: return 7'b0110000;
         4: return 7'b0011001;   5: return 7'b0010010;
         6: return 7'b0000010;   7: return 7'b1111000;
         8: return 7'b0000000;   9: return 7'b0010000;
         10: return 7'b0001000;  11: return 7'b0000011;
         12: return 7'b1000110;  13: return 7'b0100001;
         14: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   function automatic bit lz_dark(input logic [31:0] v, input int d);
`ifdef SEVENSEG_LZS_EN
      // dark if every nibble from d upward is zero, except digit 0
      if (d == 0) return 1'b0;
      return (v >> (4 * d)) == 0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_t = 0;
      m_act_val = '0; m_pend_val = '0;
      m_act_dp = '0; m_pend_dp = '0;
      m_act_blank = '0; m_pend_blank = '0;
      m_pending = 1'b0;
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk_eq({tag, "_an"},  32'(an),         32'hFF);
      chk_eq({tag, "_seg"}, 32'(seg),        32'h7F);
      chk_eq({tag, "_dp"},  32'(dp),         32'h1);
      chk_eq({tag, "_pnd"}, 32'(pending),    32'h0);
      chk_eq({tag, "_fd"},  32'(frame_done), 32'h0);
   endtask

   // One cycle: called at a negedge; checks last edge's outputs, drives inputs, predicts next edge.
   task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] pd, input logic [7:0] bl);
      int  pos, dig;
      bit  bnd, dk;
      chk_eq("an",         32'(an),         32'(exp_an));
      chk_eq("seg",        32'(seg),        32'(exp_seg));
      chk_eq("dp",         32'(dp),         32'(exp_dp));
      chk_eq("frame_done", 32'(frame_done), 32'(exp_fd));
      chk_eq("pending",    32'(pending),    32'(m_pending));
      chk_eq("an_onehot",  32'($countones(~an) <= 1), 32'h1);

      load = ld; data_in = d; dp_in = pd; blank_in = bl;

      pos = m_t % SLOT;
      dig = (m_t / SLOT) % 8;
      bnd = (m_t % FRAME) == FRAME - 1;
      dk  = (pos < GD) || m_act_blank[dig] || lz_dark(m_act_val, dig);
      exp_an  = dk ? 8'hFF : ~(8'b1 << dig);
      exp_seg = dk ? 7'h7F : ref_glyph(int'((m_act_val >> (4 * dig)) & 32'hF));
      exp_dp  = dk ? 1'b1  : ~m_act_dp[dig];
      exp_fd  = bnd;

      if (bnd) begin
         if (ld) begin
            m_act_val = d; m_act_dp = pd; m_act_blank = bl;
         end else if (m_pending) begin
            m_act_val = m_pend_val; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
         end
         m_pending = 1'b0;
      end else if (ld) begin
         m_pend_val = d; m_pend_dp = pd; m_pend_blank = bl;
         m_pending = 1'b1;
      end
      m_t++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, $urandom(), 8'($urandom()), 8'($urandom()));
   endtask

   task automatic idle_until(input int phase);
      for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != phase; i++) idle(1);
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;

      // power-up shows 0 on digit 0 after the guard window
      idle(40);

      // mid-frame load; old digits until boundary, then F E d C b A 9 8
      idle_until(40);
      step(1'b1, 32'h89ABCDEF, 8'h01, 8'h00);
      idle(2 * FRAME);

      // two loads in one frame: last one wins
      idle_until(10);
      step(1'b1, 32'h11111111, 8'h00, 8'h00);
      idle(20);
      step(1'b1, 32'h22222222, 8'h00, 8'h00);
      idle(2 * FRAME);

      // stale pending word, then a load exactly on the boundary cycle
      idle_until(100);
      step(1'b1, 32'h77777777, 8'hFF, 8'h00);
      idle_until(FRAME - 1);
      step(1'b1, 32'h00000005, 8'h00, 8'h00);
      idle(FRAME + 20);

      // upper four digits blanked
      step(1'b1, 32'h12345678, 8'hAA, 8'hF0);
      idle(2 * FRAME);

      // leading-zero patterns (plain digits when suppression is off)
      step(1'b1, 32'h00000A30, 8'h00, 8'h00);
      idle(2 * FRAME);
      step(1'b1, 32'h00000000, 8'h00, 8'h00);
      idle(2 * FRAME);

      // reset asserted mid-frame takes effect without a clock
      idle(37);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("rst_hold");
      model_reset();
      rst_n = 1'b1;
      idle(FRAME + 10);

      // random traffic
      for (int i = 0; i < 2500; i++) begin
         logic [31:0] d;
         logic [7:0]  bl;
         d  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4095)) : $urandom();
         bl = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00;
         step($urandom_range(0, 39) == 0, d, 8'($urandom()), bl);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. Consumes the 32-bit word chosen by the data-select logic (register-file or memory readout), shows it as eight hex digits, and drives the active-low segment, anode and decimal-point pins directly. New words are double-buffered and take effect only at a frame boundary, so a scan never shows a mix of old and new digits. Runs on the 100 MHz board clock with its own refresh prescaler, so no slow clock is needed from the clock divider.

## Interface
- DIV_BITS, 17: prescaler width; one digit slot lasts 2^DIV_BITS cycles (about 763 Hz digit rate, 95 Hz frame at 100 MHz).
- GUARD, 4: anti-ghosting cycles at the start of each slot with all anodes off; must be < 2^DIV_BITS.

Ports:
- CLK100MHZ  in  1  board clock.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures data_in, dp_in and blank_in.
- data_in  in  32  hex value; nibble k goes to digit k (digit 0 is rightmost, AN[0]).
- dp_in  in  8  bit k = 1 lights the decimal point of digit k.
- blank_in  in  8  bit k = 1 forces digit k dark (anode stays off).
- seg  out  7  {CG..CA}, active-low.
- an  out  8  active-low anodes, at most one low at a time.
- dp  out  1  active-low decimal point.
- pending  out  1  high while a loaded word waits for the frame boundary.
- frame_done  out  1  one-cycle pulse when digit 7's slot ends.

## Operation
- Prescaler `div` counts 0..2^DIV_BITS−1 and wraps. Slot end = `div` all-ones. At slot end, `digit` increments mod 8.
- Frame boundary = slot end while `digit` == 7. frame_done pulses in that cycle, registered, so it is visible one cycle later.
- Pending buffer: `load` writes the pending value/dp/blank and sets `pending`. A later `load` overwrites it; the last load wins.
- Active buffer: at the frame boundary, if `pending` is set, the pending buffer is copied to the active buffer and `pending` is cleared.
- Load and boundary in the same cycle: the incoming load data goes straight to the active buffer and `pending` ends low. Any older pending word is discarded.
- Output per cycle:
  - While `div` < GUARD, or blank[digit] = 1: an = 8'hFF, seg = 7'h7F, dp = 1.
  - Otherwise: an = ~(1 << digit), seg = hex decode of nibble[digit] (active-low), dp = ~dp[digit].
- Hex glyphs are standard: 0-9 and A, b, C, d, E, F. "0" = 7'b1000000 in CG..CA order.

## Timing
- Reset values:
  - an = 8'hFF, seg = 7'h7F, dp = 1.
  - pending = 0, frame_done = 0.
  - digit = 0, div = 0.
  - active and pending buffers = 0 (with blank = 0, the display shows 00000000 after the first guard window).
- Every output is registered and lags the internal `div`/`digit` state by exactly one cycle.
- Latency from `load` to visible on the display:
  - At most 8·2^DIV_BITS + GUARD + 1 cycles.
  - When the load lands on the boundary: GUARD + 1 cycles.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). Scanning resumes at digit 0, div 0, on the first clock after release.
- `load` needs no handshake and is accepted every cycle, including during reset release.

## Configuration
- SEVENSEG_LZS_EN defined: leading-zero suppression.
  - Digits above the most-significant nonzero nibble of the active value are blanked, as if their blank bit were set.
  - Digit 0 is always shown, so value 0 shows a single "0".
  - blank_in still ORs in on top of the suppression.
- Not defined: all eight digits are displayed unless blank_in masks them.

## Structure
- Package sevenseg_pkg holds:
  - NUM_DIGITS = 8.
  - The 16-entry active-low glyph constant table.
  - SEG_OFF = 7'h7F, AN_OFF = 8'hFF.
- Sub-module hex7seg: purely combinational nibble-to-glyph decode, using the package table.
- Prescaler, digit counter, buffers and output registers stay in sevenseg_scan.

## Test plan
(Scenarios use DIV_BITS = 4, GUARD = 2.)
- Reset release: an = FF, seg = 7F and dp = 1 during reset. After the first guard window, digit 0 shows "0" (seg = 7'h40) with an = FE.
- Load 32'h89ABCDEF, blank 0, dp 8'h01, mid-frame:
  - pending = 1 until the boundary; old digits remain shown before it.
  - Next frame shows F, E, d, C, b, A, 9, 8 on an FE, FD, …, 7F.
  - dp low only on digit 0.
- Two loads in one frame (1111_1111, then 2222_2222): next frame shows only 2s.
- Load 32'h5 exactly on the boundary cycle: pending stays 0, and digit 0 shows "5" GUARD + 1 cycles later.
- blank_in = 8'hF0:
  - Digits 4-7 have an = FF throughout their slots.
  - Each slot starts with a 2-cycle all-off guard.
  - Never two anodes low at once.
- With SEVENSEG_LZS_EN, load 32'h00000A30: digits 0-2 show 0, 3, A; digits 3-7 are dark. Loading 0 shows "0" on digit 0 only.
